// File: rtl/dual_lane_elastic_delay.sv
// Two independent ready/valid lanes. Each lane is a DEPTH-stage register pipeline
// that collapses bubbles under backpressure and tracks how many beats it holds.

module dual_lane_elastic_delay_lane #(
   parameter int DATA_WIDTH = 5,
   parameter int DEPTH      = 3,
   parameter int CW         = 2
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [DATA_WIDTH-1:0] in_data_i,
   input  logic                  in_valid_i,
   output logic                  in_ready_o,
   output logic [DATA_WIDTH-1:0] out_data_o,
   output logic                  out_valid_o,
   input  logic                  out_ready_i,
   output logic [CW-1:0]         count_o
);
   logic [DEPTH-1:0]      v_q, v_d;
   logic [DATA_WIDTH-1:0] d_q [DEPTH];
   logic [DATA_WIDTH-1:0] d_d [DEPTH];
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [DEPTH:0]        en;
   logic                  en_run;
   logic                  in_fire, out_fire;

   // A stage may load whenever it is empty or everything downstream of it moves.
   always_comb begin
      en        = '0;
      en_run    = out_ready_i;
      en[DEPTH] = en_run;
      for (int k = DEPTH - 1; k >= 0; k--) begin
         en_run = ~v_q[k] | en_run;
         en[k]  = en_run;
      end
   end

   assign in_ready_o  = en[0];
   assign out_valid_o = v_q[DEPTH-1];
   assign out_data_o  = d_q[DEPTH-1];
   assign count_o     = cnt_q;
   assign in_fire     = in_valid_i & en[0];
   assign out_fire    = v_q[DEPTH-1] & out_ready_i;

   always_comb begin
      v_d = v_q;
      d_d = d_q;
      if (en[0]) begin
         v_d[0] = in_valid_i;
         if (in_valid_i) begin
            d_d[0] = in_data_i;
         end
      end
      for (int k = 1; k < DEPTH; k++) begin
         if (en[k]) begin
            v_d[k] = v_q[k-1];
            if (v_q[k-1]) begin
               d_d[k] = d_q[k-1];
            end
         end
      end
   end

   always_comb begin
      cnt_d = cnt_q;
      if (in_fire && !out_fire) begin
         cnt_d = cnt_q + CW'(1);
      end else if (out_fire && !in_fire) begin
         cnt_d = cnt_q - CW'(1);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         v_q   <= '0;
         cnt_q <= '0;
         for (int k = 0; k < DEPTH; k++) begin
            d_q[k] <= '0;
         end
      end else begin
         v_q   <= v_d;
         d_q   <= d_d;
         cnt_q <= cnt_d;
      end
   end
endmodule

module dual_lane_elastic_delay #(
   parameter  int DATA_WIDTH = 5,
   parameter  int DEPTH      = 3,
   localparam int CW         = $clog2(DEPTH + 1)
) (
   input  logic                  CLK,
   input  logic                  ASYNCRESET,
   input  logic [DATA_WIDTH-1:0] I_0_data,
   input  logic                  I_0_valid,
   output logic                  I_0_ready,
   output logic [DATA_WIDTH-1:0] O_0_data,
   output logic                  O_0_valid,
   input  logic                  O_0_ready,
   output logic [CW-1:0]         COUNT_0,
   input  logic [DATA_WIDTH-1:0] I_1_data,
   input  logic                  I_1_valid,
   output logic                  I_1_ready,
   output logic [DATA_WIDTH-1:0] O_1_data,
   output logic                  O_1_valid,
   input  logic                  O_1_ready,
   output logic [CW-1:0]         COUNT_1
);
   dual_lane_elastic_delay_lane #(
      .DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH), .CW(CW)
   ) u_lane0 (
      .clk_i      (CLK),
      .rst_i      (ASYNCRESET),
      .in_data_i  (I_0_data),
      .in_valid_i (I_0_valid),
      .in_ready_o (I_0_ready),
      .out_data_o (O_0_data),
      .out_valid_o(O_0_valid),
      .out_ready_i(O_0_ready),
      .count_o    (COUNT_0)
   );

   dual_lane_elastic_delay_lane #(
      .DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH), .CW(CW)
   ) u_lane1 (
      .clk_i      (CLK),
      .rst_i      (ASYNCRESET),
      .in_data_i  (I_1_data),
      .in_valid_i (I_1_valid),
      .in_ready_o (I_1_ready),
      .out_data_o (O_1_data),
      .out_valid_o(O_1_valid),
      .out_ready_i(O_1_ready),
      .count_o    (COUNT_1)
   );
endmodule

// File: tb/tb_dual_lane_elastic_delay.sv
// Bench for dual_lane_elastic_delay: directed scenarios plus randomized traffic,
// checked against a queue model that tracks each held beat and its pipeline position.

module tb_dual_lane_elastic_delay;
   localparam int DW    = 5;
   localparam int DEPTH = 3;
   localparam int CW    = $clog2(DEPTH + 1);

   logic          CLK = 1'b0;
   logic          ASYNCRESET = 1'b1;
   logic [DW-1:0] in_d  [2];
   logic          in_v  [2];
   logic          out_r [2];
   logic [DW-1:0] o_d   [2];
   logic          o_v   [2];
   logic          i_r   [2];
   logic [CW-1:0] cnt   [2];

   int n_total = 0;
   int n_bad   = 0;

   // model: per lane, held beats oldest first, with data and stage position
   int md [2][DEPTH];
   int mp [2][DEPTH];
   int mn [2];

   always #5 CLK = ~CLK;

   dual_lane_elastic_delay #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
      .CLK       (CLK),
      .ASYNCRESET(ASYNCRESET),
      .I_0_data  (in_d[0]),
      .I_0_valid (in_v[0]),
      .I_0_ready (i_r[0]),
      .O_0_data  (o_d[0]),
      .O_0_valid (o_v[0]),
      .O_0_ready (out_r[0]),
      .COUNT_0   (cnt[0]),
      .I_1_data  (in_d[1]),
      .I_1_valid (in_v[1]),
      .I_1_ready (i_r[1]),
      .O_1_data  (o_d[1]),
      .O_1_valid (o_v[1]),
      .O_1_ready (out_r[1]),
      .COUNT_1   (cnt[1])
   );

   task automatic chk(input string tag, input int obs, input int exp);
      n_total++;
      if (obs != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic bit exp_ov(input int l);
      return (mn[l] > 0) && (mp[l][0] == DEPTH - 1);
   endfunction

   function automatic bit exp_ir(input int l);
      return (mn[l] < DEPTH) || (out_r[l] == 1'b1);
   endfunction

   task automatic check_lanes();
      for (int l = 0; l < 2; l++) begin
         chk($sformatf("L%0d o_valid", l), int'(o_v[l]), int'(exp_ov(l)));
         if (exp_ov(l)) chk($sformatf("L%0d o_data", l), int'(o_d[l]), md[l][0]);
         chk($sformatf("L%0d i_ready", l), int'(i_r[l]), int'(exp_ir(l)));
         chk($sformatf("L%0d count", l), int'(cnt[l]), mn[l]);
      end
   endtask

   // Advance the model across one clock edge: pop on out-fire, every beat
   // moves one stage closer unless blocked by the beat ahead, push on in-fire.
   task automatic model_step();
      for (int l = 0; l < 2; l++) begin
         bit ofire;
         bit ifire;
         int lim;
         ofire = exp_ov(l) && (out_r[l] == 1'b1) && !ASYNCRESET;
         ifire = (in_v[l] == 1'b1) && exp_ir(l) && !ASYNCRESET;
         if (ofire) begin
            for (int i = 1; i < mn[l]; i++) begin
               md[l][i-1] = md[l][i];
               mp[l][i-1] = mp[l][i];
            end
            mn[l]--;
         end
         for (int i = 0; i < mn[l]; i++) begin
            lim = (i == 0) ? DEPTH - 1 : mp[l][i-1] - 1;
            mp[l][i] = (mp[l][i] + 1 < lim) ? mp[l][i] + 1 : lim;
         end
         if (ifire) begin
            md[l][mn[l]] = int'(in_d[l]);
            mp[l][mn[l]] = 0;
            mn[l]++;
         end
      end
   endtask

   task automatic cyc();
      @(negedge CLK);
      check_lanes();
      model_step();
      @(posedge CLK);
      #1;
   endtask

   initial begin
      int b;
      int idx;
      int pv;
      int pr [2];
      bit fire;
      logic [DW-1:0] t4 [3];

      for (int l = 0; l < 2; l++) begin
         in_d[l] = '0; in_v[l] = 1'b0; out_r[l] = 1'b0; mn[l] = 0;
      end
      #1;
      for (int l = 0; l < 2; l++) begin
         chk("rst o_valid", int'(o_v[l]), 0);
         chk("rst o_data", int'(o_d[l]), 0);
         chk("rst i_ready", int'(i_r[l]), 1);
         chk("rst count", int'(cnt[l]), 0);
      end
      @(posedge CLK); #1;
      ASYNCRESET = 1'b0;

      // single beat latency
      out_r[0] = 1'b1; in_v[0] = 1'b1; in_d[0] = 5'h15;
      cyc();
      in_v[0] = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         chk($sformatf("T1 o_valid k=%0d", k), int'(o_v[0]), (k == 3) ? 1 : 0);
         chk($sformatf("T1 count k=%0d", k), int'(cnt[0]), (k <= 3) ? 1 : 0);
         if (k == 3) chk("T1 o_data", int'(o_d[0]), 'h15);
         cyc();
      end

      // lane 1 filled and stalled while lane 0 streams 0..9
      out_r[1] = 1'b0;
      for (int k = 0; k < 3; k++) begin
         in_v[1] = 1'b1; in_d[1] = DW'(20 + k);
         cyc();
      end
      in_v[1] = 1'b0;
      out_r[0] = 1'b1;
      for (int c = 0; c < 15; c++) begin
         in_v[0] = (c < 10);
         in_d[0] = DW'(c);
         chk("T2 i_ready", int'(i_r[0]), 1);
         chk("T5 count1", int'(cnt[1]), 3);
         chk("T5 o_valid1", int'(o_v[1]), 1);
         chk("T5 o_data1", int'(o_d[1]), 20);
         if (c >= 3 && c < 13) begin
            chk("T2 o_valid", int'(o_v[0]), 1);
            chk("T2 o_data", int'(o_d[0]), c - 3);
         end
         cyc();
      end
      in_v[0] = 1'b0;
      out_r[1] = 1'b1;
      for (int c = 0; c < 4; c++) cyc();

      // backpressure: offer 5 beats into a stalled lane
      out_r[0] = 1'b0;
      b = 1;
      for (int c = 0; c < 7; c++) begin
         in_v[0] = (b <= 5);
         in_d[0] = DW'(b);
         fire = in_v[0] && i_r[0];
         cyc();
         if (fire) b++;
      end
      chk("T3 count full", int'(cnt[0]), 3);
      chk("T3 i_ready full", int'(i_r[0]), 0);
      chk("T3 accepted", b, 4);
      out_r[0] = 1'b1;
      #1;
      chk("T3 i_ready release", int'(i_r[0]), 1);
      idx = 1;
      for (int c = 0; c < 12; c++) begin
         in_v[0] = (b <= 5);
         in_d[0] = DW'(b);
         fire = in_v[0] && i_r[0];
         if (o_v[0] && out_r[0]) begin
            chk("T3 order", int'(o_d[0]), idx);
            idx++;
         end
         cyc();
         if (fire) b++;
      end
      chk("T3 all drained", idx, 6);

      // bubble collapse
      t4[0] = 5'h0A; t4[1] = 5'h0B; t4[2] = 5'h0C;
      out_r[0] = 1'b0;
      for (int c = 0; c < 6; c++) begin
         in_v[0] = (c % 2 == 0);
         in_d[0] = t4[c/2];
         cyc();
      end
      in_v[0] = 1'b0;
      chk("T4 count", int'(cnt[0]), 3);
      out_r[0] = 1'b1;
      for (int c = 0; c < 3; c++) begin
         chk("T4 drain valid", int'(o_v[0]), 1);
         chk("T4 drain data", int'(o_d[0]), int'(t4[c]));
         cyc();
      end
      chk("T4 empty", int'(o_v[0]), 0);

      // reset with beats in flight
      out_r[0] = 1'b0; out_r[1] = 1'b0;
      for (int c = 0; c < 2; c++) begin
         for (int l = 0; l < 2; l++) begin
            in_v[l] = 1'b1; in_d[l] = DW'($urandom());
         end
         cyc();
      end
      in_v[0] = 1'b0; in_v[1] = 1'b0;
      cyc();
      chk("T6 held0", int'(cnt[0]), 2);
      chk("T6 held1", int'(cnt[1]), 2);
      #2;
      ASYNCRESET = 1'b1;
      #1;
      for (int l = 0; l < 2; l++) begin
         chk("T6 o_valid", int'(o_v[l]), 0);
         chk("T6 o_data", int'(o_d[l]), 0);
         chk("T6 count", int'(cnt[l]), 0);
         chk("T6 i_ready", int'(i_r[l]), 1);
         mn[l] = 0;
      end
      cyc();
      ASYNCRESET = 1'b0;
      out_r[0] = 1'b1; out_r[1] = 1'b1;
      for (int c = 0; c < 8; c++) cyc();

      // randomized traffic with varying backpressure
      pv = 50; pr[0] = 50; pr[1] = 50;
      for (int c = 0; c < 3000; c++) begin
         if (c % 200 == 0) begin
            pv    = $urandom_range(20, 100);
            pr[0] = $urandom_range(0, 100);
            pr[1] = $urandom_range(0, 100);
         end
         for (int l = 0; l < 2; l++) begin
            in_v[l]  = ($urandom_range(0, 99) < pv);
            in_d[l]  = DW'($urandom());
            out_r[l] = ($urandom_range(0, 99) < pr[l]);
         end
         cyc();
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule
